// File: rtl/wbck_port_arbiter.sv
// Round-robin arbiter sharing the register-file write-back port among NREQ producers,
// feeding a one-entry registered output slot with full-throughput drain/refill.
module wbck_port_arbiter #(
  parameter int NREQ   = 3,
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*RIDX_W-1:0] req_rdidx,
  input  logic [NREQ*XLEN-1:0]   req_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [RIDX_W-1:0]      wb_rdidx,
  output logic [XLEN-1:0]        wb_data
);

  localparam int          PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N     = NREQ;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e           state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_found;
  logic                  can_load;
  logic                  load;
  logic [RIDX_W-1:0]     sel_rdidx;
  logic [XLEN-1:0]       sel_data;
  logic [RIDX_W-1:0]     rd_arr [NREQ];
  logic [XLEN-1:0]       dt_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rd_arr[i] = req_rdidx[i*RIDX_W +: RIDX_W];
    assign dt_arr[i] = req_data[i*XLEN +: XLEN];
  end

  assign wb_valid = (state_q == FULL);
  assign can_load = (state_q == EMPTY) || wb_ready;

  // Search starts just after the last winner; the first valid hit stops the scan.
  always_comb begin : grant
    int unsigned      idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_rdidx = '0;
    sel_data  = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= N) idx = idx - N;
      cand = PTR_W'(idx);
      if (rst_n && can_load && !gnt_found && req_valid[cand]) begin
        gnt_found       = 1'b1;
        gnt_idx         = cand;
        req_ready[cand] = 1'b1;
        sel_rdidx       = rd_arr[cand];
        sel_data        = dt_arr[cand];
      end
    end
  end

  // An x0 destination completes the handshake but never occupies the slot.
  always_comb begin : next_state
    state_d = state_q;
    load    = gnt_found && (sel_rdidx != '0);
    if (load) begin
      state_d = FULL;
    end else if (state_q == FULL && wb_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= PTR_W'(NREQ - 1);
      wb_rdidx <= '0;
      wb_data  <= '0;
    end else begin
      if (gnt_found) rr_ptr <= gnt_idx;
      if (load) begin
        wb_rdidx <= sel_rdidx;
        wb_data  <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wbck_port_arbiter.sv
// Directed and randomized checks of wbck_port_arbiter against a transaction-level
// model: modulo round-robin search plus a one-entry slot.
module tb_wbck_port_arbiter;
  localparam int NREQ   = 3;
  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*RIDX_W-1:0] req_rdidx;
  logic [NREQ*XLEN-1:0]   req_data;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [RIDX_W-1:0]      wb_rdidx;
  logic [XLEN-1:0]        wb_data;

  logic [NREQ-1:0]   v;
  logic [RIDX_W-1:0] rd [NREQ];
  logic [XLEN-1:0]   dt [NREQ];
  logic              wbr;

  int checks   = 0;
  int failures = 0;

  int                rr;
  bit                mv;
  logic [RIDX_W-1:0] mrd;
  logic [XLEN-1:0]   mdat;
  int                last_g;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = v;
    wb_ready  = wbr;
    for (int i = 0; i < NREQ; i++) begin
      req_rdidx[i*RIDX_W +: RIDX_W] = rd[i];
      req_data[i*XLEN +: XLEN]      = dt[i];
    end
  end

  wbck_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rdidx(req_rdidx),
    .req_data (req_data),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rdidx (wb_rdidx),
    .wb_data  (wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr   = NREQ - 1;
    mv   = 1'b0;
    mrd  = '0;
    mdat = '0;
  endtask

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (mv && !wbr) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] e;
    int g;
    e = '0;
    g = exp_grant();
    if (g >= 0) e[g] = 1'b1;
    return e;
  endfunction

  task automatic model_update();
    int g;
    g      = exp_grant();
    last_g = g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (g >= 0) begin
      rr = g;
      if (rd[g] != 0) begin
        mv   = 1'b1;
        mrd  = rd[g];
        mdat = dt[g];
      end else if (mv && wbr) begin
        mv = 1'b0;
      end
    end else if (mv && wbr) begin
      mv = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("req_ready", 64'(req_ready), 64'(exp_ready()));
    chk("wb_valid",  64'(wb_valid),  64'(mv));
    chk("wb_rdidx",  64'(wb_rdidx),  64'(mrd));
    chk("wb_data",   64'(wb_data),   64'(mdat));
  endtask

  // Entered at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    wbr   = 1'b0;
    v     = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = '0;
      dt[i] = '0;
    end
    model_reset();
    last_g = -1;
    @(negedge clk);

    // T1: reset holds everything quiet regardless of inputs
    for (int c = 0; c < 4; c++) begin
      v   = NREQ'($urandom);
      wbr = 1'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        rd[i] = RIDX_W'($urandom);
        dt[i] = $urandom;
      end
      step();
    end
    rst_n = 1'b1;
    v     = '0;
    wbr   = 1'b1;
    step();

    // T2: single stream from requester 0
    v = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      rd[0] = RIDX_W'(k);
      dt[0] = $urandom;
      step();
    end
    v = '0;
    step();

    // T3: all requesting, grant rotates 1,2,0,... after requester 0 won last
    v = 3'b111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        rd[i] = RIDX_W'(i + 1 + 3 * k);
        dt[i] = $urandom;
      end
      #1;
      chk("t3_seq", 64'(req_ready), 64'(1 << ((k + 1) % NREQ)));
      step();
    end

    // T4: backpressure with a full slot, then same-cycle drain and reload
    v     = 3'b001;
    rd[0] = 5'd7;
    dt[0] = 32'hA5A5_0007;
    step();
    wbr = 1'b0;
    v   = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_ready", 64'(req_ready), 64'(0));
      chk("t4_stall_data",  64'(wb_data),   64'(32'hA5A5_0007));
      step();
    end
    wbr = 1'b1;
    step();
    v = '0;
    #1;
    chk("t4_refill_valid", 64'(wb_valid), 64'(1));
    step();

    // T5: x0 result is acknowledged and dropped
    v     = 3'b010;
    rd[1] = '0;
    dt[1] = 32'h0000_DEAD;
    #1;
    chk("t5_x0_ready", 64'(req_ready), 64'(3'b010));
    step();
    v = 3'b111;
    for (int i = 0; i < NREQ; i++) rd[i] = RIDX_W'(20 + i);
    #1;
    chk("t5_no_pulse",   64'(wb_valid),  64'(0));
    chk("t5_next_grant", 64'(req_ready), 64'(3'b100));
    step();

    // T6: async reset during a stall
    v     = 3'b001;
    rd[0] = 5'd9;
    dt[0] = 32'h1234_5678;
    wbr   = 1'b1;
    step();
    v   = '0;
    wbr = 1'b0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(wb_valid),  64'(0));
    chk("t6_async_rdidx", 64'(wb_rdidx),  64'(0));
    chk("t6_async_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    v     = 3'b111;
    wbr   = 1'b1;
    #1;
    chk("t6_first_grant", 64'(req_ready), 64'(3'b001));
    step();

    // Randomized traffic obeying the hold-until-handshake requester rule
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && ($urandom % 2 == 0)) begin
          v[i]  = 1'b1;
          rd[i] = RIDX_W'($urandom_range(0, 7));
          dt[i] = $urandom;
        end
      end
      wbr = ($urandom % 4) != 0;
      step();
      if (last_g >= 0) v[last_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
